// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_scan_ctrl                                                |
// | Description : Bus-configurable scan controller for an 8-digit multiplexed  |
// |               seven-segment display. Digits 7..0 are driven in turn with a |
// |               blanking gap between them. Anodes and cathodes are active    |
// |               low, and frame_done pulses once per full scan.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 25000,  // cycles each digit is driven, >= 1
  parameter int BLANK_CYC = 16      // cycles of blanking between digits, 0 = none
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [1:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic [1:0]  i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [7:0]  o_sseg_an,
  output logic [7:0]  o_sseg_ca,
  output logic        o_frame_done
);

  // One counter serves both the drive dwell and the blanking gap.
  localparam int c_CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CW-1:0] c_DRV_LAST = c_CW'(CLK_DIV - 1);
  localparam logic [c_CW-1:0] c_BLK_LAST = c_CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  localparam logic [0:0] c_DRIVE = 1'b0;
  localparam logic [0:0] c_BLANK = 1'b1;

  logic [31:0]     r_data;
  logic [7:0]      r_en;
  logic [7:0]      r_dp;
  logic [1:0]      r_ctrl;
  logic [0:0]      r_state;
  logic [2:0]      r_idx;
  logic [c_CW-1:0] r_cnt;
  logic [7:0]      r_an;
  logic [7:0]      r_ca;
  logic            r_frame_done;

  logic       w_disp_on;
  logic       w_hold;
  logic [3:0] w_nib;
  logic [7:0] w_seg;
  logic       w_lit;
  logic [7:0] w_an_nxt;
  logic [7:0] w_ca_nxt;
  logic       w_drv_end;
  logic       w_blk_end;
  logic       w_slot_end;

  assign w_disp_on = r_ctrl[0];
  assign w_hold    = r_ctrl[1];
  assign w_nib     = r_data[{r_idx, 2'b00} +: 4];

  // Register file writes; one write per cycle at most.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= 32'h0;
      r_en   <= 8'hFF;
      r_dp   <= 8'h00;
      r_ctrl <= 2'b01;
    end else if (i_wr_en) begin
      case (i_wr_addr)
        2'd0:    r_data <= i_wr_data;
        2'd1:    r_en   <= i_wr_data[7:0];
        2'd2:    r_dp   <= i_wr_data[7:0];
        default: r_ctrl <= i_wr_data[1:0];
      endcase
    end
  end

  // Combinational readback; reads never disturb state.
  always_comb begin
    o_rd_data = 32'h0;
    case (i_rd_addr)
      2'd0:    o_rd_data = r_data;
      2'd1:    o_rd_data = {24'h0, r_en};
      2'd2:    o_rd_data = {24'h0, r_dp};
      default: o_rd_data = {30'h0, r_ctrl};
    endcase
  end

  // Hex nibble to segment pattern {a..g, dp}, dp off.
  always_comb begin
    w_seg = 8'hFF;
    case (w_nib)
      4'h0: w_seg = 8'h03;
      4'h1: w_seg = 8'h9F;
      4'h2: w_seg = 8'h25;
      4'h3: w_seg = 8'h0D;
      4'h4: w_seg = 8'h99;
      4'h5: w_seg = 8'h49;
      4'h6: w_seg = 8'h41;
      4'h7: w_seg = 8'h1F;
      4'h8: w_seg = 8'h01;
      4'h9: w_seg = 8'h09;
      4'hA: w_seg = 8'h11;
      4'hB: w_seg = 8'hC1;
      4'hC: w_seg = 8'h63;
      4'hD: w_seg = 8'h85;
      4'hE: w_seg = 8'h61;
      default: w_seg = 8'h71;
    endcase
  end

  assign w_lit     = (r_state == c_DRIVE) && r_en[r_idx] && w_disp_on;
  assign w_an_nxt  = w_lit ? ~(8'b1 << r_idx) : 8'hFF;
  assign w_ca_nxt  = w_lit ? {w_seg[7:1], ~r_dp[r_idx]} : 8'hFF;
  assign w_drv_end = (r_state == c_DRIVE) && (r_cnt == c_DRV_LAST);
  assign w_blk_end = (r_state == c_BLANK) && (r_cnt == c_BLK_LAST);
  // Without a blanking gap the slot ends with the drive dwell itself.
  assign w_slot_end = (BLANK_CYC == 0) ? w_drv_end : w_blk_end;

  // Scan sequencer and registered outputs; hold freezes everything in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_DRIVE;
      r_idx        <= 3'd7;
      r_cnt        <= '0;
      r_an         <= 8'hFF;
      r_ca         <= 8'hFF;
      r_frame_done <= 1'b0;
    end else if (!w_hold) begin
      r_an         <= w_an_nxt;
      r_ca         <= w_ca_nxt;
      r_frame_done <= w_slot_end && (r_idx == 3'd0);
      if (r_state == c_DRIVE) begin
        if (r_cnt == c_DRV_LAST) begin
          r_cnt <= '0;
          if (BLANK_CYC == 0) begin
            r_idx <= r_idx - 3'd1;
          end else begin
            r_state <= c_BLANK;
          end
        end else begin
          r_cnt <= r_cnt + c_CW'(1);
        end
      end else begin
        if (r_cnt == c_BLK_LAST) begin
          r_cnt   <= '0;
          r_idx   <= r_idx - 3'd1;
          r_state <= c_DRIVE;
        end else begin
          r_cnt <= r_cnt + c_CW'(1);
        end
      end
    end else begin
      r_frame_done <= 1'b0;
    end
  end

  assign o_sseg_an    = r_an;
  assign o_sseg_ca    = r_ca;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire
